// File: rtl/bus_pkg.sv
// Shared bus definitions for masters on the 8-bit-data / 16-bit-address memory bus.
package bus_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 16;

   typedef logic [DATA_WIDTH-1:0] bus_data_t;
   typedef logic [ADDR_WIDTH-1:0] bus_addr_t;

   typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT, REL} bus_dma_state_t;
endpackage

// File: rtl/bus_master_drv.sv
// Owner-gated tri-state drivers for a secondary bus master; everything floats
// unless owner is high.
module bus_master_drv #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  owner,
   input  logic                  mreq_n_i,
   input  logic                  rd_n_i,
   input  logic                  wr_n_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output wire                   mreq_n,
   output wire                   iorq_n,
   output wire                   rd_n,
   output wire                   wr_n,
   output wire  [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data
);
   assign mreq_n = owner ? mreq_n_i : 1'bz;
   assign iorq_n = owner ? 1'b1     : 1'bz;
   assign rd_n   = owner ? rd_n_i   : 1'bz;
   assign wr_n   = owner ? wr_n_i   : 1'bz;
   assign addr   = owner ? addr_i   : {ADDR_WIDTH{1'bz}};
   // Data is only driven during our own write strobe.
   assign data   = (owner && !wr_n_i) ? wdata_i : {DATA_WIDTH{1'bz}};
endmodule

// File: rtl/bus_dma.sv
// Memory-to-memory DMA master: requests the shared bus, copies len bytes src->dst,
// releases the bus. Optional BUS_DMA_CYCLE_STEAL_EN releases the bus between bytes.
module bus_dma #(
   parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  busrq_n,
   input  logic                  busack_n,
   output wire                   mreq_n,
   output wire                   iorq_n,
   output wire                   rd_n,
   output wire                   wr_n,
   output wire  [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data,
   input  logic                  buswait_n
);
   import bus_pkg::*;

   bus_dma_state_t        state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_v;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] latch_q, latch_d;
   logic                  done_q, done_d;
   logic                  owner, wait_s, mreq_v, rd_v, wr_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         latch_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         latch_q <= latch_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      latch_d = latch_q;
      done_d  = 1'b0;
      busrq_n = 1'b1;
      mreq_v  = 1'b1;
      rd_v    = 1'b1;
      wr_v    = 1'b1;
      addr_v  = src_q;
      // Only an explicit 0 is a wait; Z or 1 both mean ready.
      wait_s  = (buswait_n == 1'b0);
      owner   = ((state_q == RD) || (state_q == WR) || (state_q == NEXT)) && !busack_n;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  cnt_d   = len;
                  state_d = REQ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         REQ: begin
            busrq_n = 1'b0;
            if (!busack_n) state_d = RD;
         end
         RD: begin
            busrq_n = 1'b0;
            mreq_v  = 1'b0;
            rd_v    = 1'b0;
            if (busack_n) begin
               state_d = REQ;
            end else if (!wait_s) begin
               latch_d = data;
               state_d = WR;
            end
         end
         WR: begin
            busrq_n = 1'b0;
            mreq_v  = 1'b0;
            wr_v    = 1'b0;
            addr_v  = dst_q;
            if (busack_n)     state_d = REQ;
            else if (!wait_s) state_d = NEXT;
         end
         NEXT: begin
            busrq_n = 1'b0;
            addr_v  = dst_q;
            // Losing the grant here re-copies the same byte, which is harmless.
            if (busack_n) begin
               state_d = REQ;
            end else begin
               src_d = src_q + 1'b1;
               dst_d = dst_q + 1'b1;
               cnt_d = cnt_q - LEN_WIDTH'(1);
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = REL;
               end else begin
`ifdef BUS_DMA_CYCLE_STEAL_EN
                  state_d = REL;
`else
                  state_d = RD;
`endif
               end
            end
         end
         REL: begin
            // A non-zero count here is a between-bytes release, so come back.
            if (busack_n) begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

   bus_master_drv #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_drv (
      .owner    (owner),
      .mreq_n_i (mreq_v),
      .rd_n_i   (rd_v),
      .wr_n_i   (wr_v),
      .addr_i   (addr_v),
      .wdata_i  (latch_q),
      .mreq_n   (mreq_n),
      .iorq_n   (iorq_n),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .addr     (addr),
      .data     (data)
   );
endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: CPU grant model, pulled-up shared bus, one memory
// covering periph0 (0x0000) and periph1 (0x8000) with optional post-write wait.
module tb_bus_dma;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
   logic        busy, done, busrq_n;
   logic        busack_n = 1'b1;
   logic        buswait_n;
   tri1         mreq_n, iorq_n, rd_n, wr_n;
   tri1  [15:0] addr;
   tri1  [7:0]  data;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_a = '0;
   logic [7:0]  poke_v = '0;
   logic        wr_wait_en = 1'b0;
   int          wait_cnt = 0;

   int          done_cnt, done_cyc, rq_rises, wr_cnt, wr_at_done, rd_cycles, nrd;
   logic [15:0] rd_addr [4];
   logic        rq_low, touched, busy_first;

   bus_dma dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .busy(busy), .done(done), .busrq_n(busrq_n), .busack_n(busack_n),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr),
      .data(data), .buswait_n(buswait_n)
   );

   always #5 clk = ~clk;

   // CPU grants one cycle after seeing a request and releases one cycle after it drops.
   always @(posedge clk) busack_n <= busrq_n;

   assign buswait_n = (wait_cnt == 0);
   assign data = (mreq_n === 1'b0 && rd_n === 1'b0) ? mem[addr] : 8'bz;

   always @(posedge clk) begin
      if (poke_en) mem[poke_a] <= poke_v;
      if (mreq_n === 1'b0 && wr_n === 1'b0 && buswait_n) begin
         mem[addr] <= data;
         if (wr_wait_en) wait_cnt <= 3;
      end else if (wait_cnt != 0) begin
         wait_cnt <= wait_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      poke_a = a; poke_v = v; poke_en = 1'b1;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic sample(input int k, inout logic prev_rq, inout logic prev_rd, inout logic prev_wr);
      logic rd_act, wr_act;
      rd_act = (mreq_n === 1'b0 && rd_n === 1'b0);
      wr_act = (mreq_n === 1'b0 && wr_n === 1'b0);
      if (wr_act && !prev_wr) wr_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         if (done_cyc < 0) begin done_cyc = k; wr_at_done = wr_cnt; end
      end
      if (busrq_n === 1'b1 && prev_rq === 1'b0) rq_rises++;
      if (busrq_n === 1'b0) rq_low = 1'b1;
      if (mreq_n !== 1'b1 || addr !== 16'hFFFF) touched = 1'b1;
      if (rd_act) begin
         rd_cycles++;
         if (!prev_rd && nrd < 4) begin rd_addr[nrd] = addr; nrd++; end
      end
      prev_rq = busrq_n; prev_rd = rd_act; prev_wr = wr_act;
   endtask

   // Index k counts negedges after the edge that accepted start (k=0 is the first).
   task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                           input int ncyc);
      logic prev_rq, prev_rd, prev_wr;
      done_cnt = 0; done_cyc = -1; rq_rises = 0; wr_cnt = 0; wr_at_done = -1;
      rd_cycles = 0; nrd = 0; rq_low = 1'b0; touched = 1'b0;
      prev_rq = 1'b1; prev_rd = 1'b0; prev_wr = 1'b0;
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_first = busy;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) @(negedge clk);
         sample(k, prev_rq, prev_rd, prev_wr);
      end
   endtask

   initial begin
      int   wseen, dpost;
      logic prq, prd, pwr;

      repeat (3) @(negedge clk);
      chk("rst_busrq_n", busrq_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mreq_z", mreq_n, 1);
      chk("rst_iorq_z", iorq_n, 1);
      chk("rst_addr_z", addr, 16'hFFFF);
      chk("rst_data_z", data, 8'hFF);
      reset = 1'b0;
      @(negedge clk);

      poke(16'h8000, 8'h10);
      poke(16'h8001, 8'h11);
      run_xfer(16'h8000, 16'h0002, 16'd2, 20);
      chk("burst_busy", busy_first, 1);
      chk("burst_done_cyc", done_cyc, 10);
      chk("burst_done_cnt", done_cnt, 1);
      chk("burst_rq_rises", rq_rises, 1);
      chk("burst_rd_cycles", rd_cycles, 2);
      chk("burst_mem2", mem[16'h0002], 8'h10);
      chk("burst_mem3", mem[16'h0003], 8'h11);
      chk("burst_busrq_after", busrq_n, 1);
      chk("burst_busy_after", busy, 0);

      poke(16'h0002, 8'h00);
      poke(16'h0003, 8'h00);
      wr_wait_en = 1'b1;
      run_xfer(16'h8000, 16'h0002, 16'd2, 20);
      wr_wait_en = 1'b0;
      chk("wwait_done_cyc", done_cyc, 12);
      chk("wwait_rd_cycles", rd_cycles, 4);
      chk("wwait_mem2", mem[16'h0002], 8'h10);
      chk("wwait_mem3", mem[16'h0003], 8'h11);

      run_xfer(16'h1234, 16'h4321, 16'd0, 8);
      chk("len0_done_cyc", done_cyc, 0);
      chk("len0_done_cnt", done_cnt, 1);
      chk("len0_no_busrq", rq_low, 0);
      chk("len0_bus_z", touched, 0);

      poke(16'hFFFF, 8'hA5);
      poke(16'h0000, 8'h5A);
      poke(16'h0001, 8'h00);
      run_xfer(16'hFFFF, 16'h0000, 16'd2, 20);
      chk("wrap_rd0", rd_addr[0], 16'hFFFF);
      chk("wrap_rd1", rd_addr[1], 16'h0000);
      chk("wrap_mem0", mem[16'h0000], 8'hA5);
      chk("wrap_mem1", mem[16'h0001], 8'hA5);

      poke(16'h8010, 8'h21);
      poke(16'h8011, 8'h22);
      poke(16'h8012, 8'h23);
      run_xfer(16'h8010, 16'h0010, 16'd3, 40);
`ifdef BUS_DMA_CYCLE_STEAL_EN
      chk("len3_rq_rises", rq_rises, 3);
`else
      chk("len3_rq_rises", rq_rises, 1);
`endif
      chk("len3_done_cnt", done_cnt, 1);
      chk("len3_wr_at_done", wr_at_done, 3);
      chk("len3_mem10", mem[16'h0010], 8'h21);
      chk("len3_mem12", mem[16'h0012], 8'h23);

      // Reset while the second byte's write strobe is on the bus.
      wr_cnt = 0; prq = 1'b1; prd = 1'b0; pwr = 1'b0;
      done_cnt = 0; done_cyc = -1; nrd = 0; rd_cycles = 0; rq_rises = 0;
      src_addr = 16'h8000; dst_addr = 16'h0002; len = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wseen = 0;
      for (int k = 0; k < 30 && wseen == 0; k++) begin
         if (k > 0) @(negedge clk);
         sample(k, prq, prd, pwr);
         if (wr_cnt == 2) wseen = 1;
      end
      chk("rst_wr1_reached", wseen, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busrq_n", busrq_n, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mreq_z", mreq_n, 1);
      chk("mid_rst_rd_z", rd_n, 1);
      chk("mid_rst_wr_z", wr_n, 1);
      chk("mid_rst_addr_z", addr, 16'hFFFF);
      chk("mid_rst_data_z", data, 8'hFF);
      reset = 1'b0;
      dpost = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) dpost++;
      end
      chk("mid_rst_no_done", dpost, 0);
      chk("mid_rst_idle_busrq", busrq_n, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Secondary bus master for the shared 8-bit-data / 16-bit-address memory bus.
- Requests the bus from the CPU with busrq_n and waits for busack_n.
- Once granted, copies a block of bytes memory-to-memory (read src, write dst) using the same mreq_n/rd_n/wr_n/buswait_n cycle rules as the CPU.
- Then releases the bus. Sits beside the CPU on the shared bus; control is via a local start/busy/done interface.

Parameters:
- DATA_WIDTH, 8, bus data width (from shared package).
- ADDR_WIDTH, 16, bus address width (from shared package).
- LEN_WIDTH, 16, width of the transfer byte count.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches src/dst/len when IDLE.
- src_addr  input  ADDR_WIDTH  first source address.
- dst_addr  input  ADDR_WIDTH  first destination address.
- len  input  LEN_WIDTH  byte count; 0 is legal.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transfer completes and the bus is released.
- busrq_n  output  1  bus request, active low.
- busack_n  input  1  bus grant from the CPU, active low.
- mreq_n  output  1  memory request; driven only while owner, else Z.
- iorq_n  output  1  driven 1 while owner, else Z.
- rd_n  output  1  read strobe; driven only while owner, else Z.
- wr_n  output  1  write strobe; driven only while owner, else Z.
- addr  output  ADDR_WIDTH  bus address; driven only while owner, else Z.
- data  inout  DATA_WIDTH  driven only while owner and wr_n=0, else Z.
- buswait_n  input  1  wait from the addressed peripheral; Z/1 means ready.

Behaviour:
- Reset values: busrq_n=1, busy=0, done=0, all bus outputs Z, state IDLE. Reset mid-transfer releases the bus on the next edge; no done pulse.
- owner = (state in RD, WR, NEXT) && busack_n==0.
  - All bus drivers are gated combinationally by owner.
  - Any buswait_n value other than 0 (including Z) counts as ready.
- IDLE:
  - start with len!=0 → latch src/dst/len, go to REQ.
  - start with len==0 → done=1 next cycle, no bus request.
  - start while busy is ignored.
- REQ: busrq_n=0. When busack_n is sampled 0 → RD.
- RD: mreq_n=0, rd_n=0, wr_n=1, addr=src.
  - On an edge with buswait_n sampled 0: hold state, no capture.
  - Otherwise: capture data into the byte latch, go to WR. Minimum one cycle.
- WR: mreq_n=0, rd_n=1, wr_n=0, addr=dst, data=latch.
  - Leave on the first edge with buswait_n not 0.
  - Wait asserted by the peripheral in response to the write (seen from the next cycle) is honoured by the following RD.
- NEXT: mreq_n=1, rd_n=1, wr_n=1. src++, dst++ (wrap modulo 2^ADDR_WIDTH), cnt--.
  - cnt becomes 0 → REL; else → RD.
- REL: busrq_n=1, bus outputs Z. When busack_n is sampled 1 → IDLE with done=1 for one cycle; busy falls the same cycle.
- Grant lost (busack_n=1) in RD/WR/NEXT: tri-state immediately and return to REQ.
  - src/dst/cnt are held.
  - An incomplete RD or WR is restarted from RD of the same byte.
- Steady-state throughput with no waits: 3 cycles per byte.

Optional Feature:
- Macro BUS_DMA_CYCLE_STEAL_EN.
- Defined: after each NEXT with cnt!=0, go to REL-style release: busrq_n=1 and bus Z for at least one cycle until busack_n is sampled 1, then REQ again. This lets the CPU run between bytes. No done pulse until the final byte.
- Undefined: burst mode; the bus is held for the whole transfer.

Decomposition:
- Shared package bus_pkg: DATA_WIDTH, ADDR_WIDTH, bus_data_t, bus_addr_t, and the bus_dma_state_t enum (IDLE, REQ, RD, WR, NEXT, REL).
- One sub-module, bus_master_drv: the owner-gated tri-state drivers for mreq_n, iorq_n, rd_n, wr_n, addr and data. Intended for reuse by future masters.

Test Plan:
- Bench setup: the CPU holds busack_n=1 until it sees busrq_n=0, then grants. Peripheral ID0 is mapped at 0x0000 and ID1 at 0x8000.
- Burst copy: src=0x8000, dst=0x0002, len=2 → periph0 mem[2]=0x10, mem[3]=0x11; one done pulse; busrq_n=1 afterwards.
- Write wait: the same copy with periph0 asserting a 2-cycle wait after each write → the second RD stretches by 2 cycles; data is still correct.
- len=0 → done on the cycle after start; busrq_n stays 1; bus stays Z throughout.
- Wrap: src=0xFFFF, dst=0x0000, len=2 → reads 0xFFFF then 0x0000 (wrapped).
- Reset during WR of byte 1 → the next cycle has all bus outputs Z, busrq_n=1, busy=0; no done pulse.
- Cycle steal (macro defined), len=3 → busrq_n deasserts between bytes exactly 2 times; done after the 3rd write.
